cmos_capture_rgb565: RTL and testbench
======================================

Name: cmos_capture_rgb565

Overview:
- Camera front-end capture stage for the OV5640 DVP port, running in the camera pixel-clock domain.
- Packs byte pairs into RGB565 words and discards a configurable number of start-up frames.
- Drives the frame-buffer write interface: write enable, 16-bit data, and a frame-valid that gates bank switching.
- Reports frame-size errors and a frame counter for debug.

Parameters:
- FRAME_SKIP, 10, number of whole frames discarded after sdram init before capture starts (0..255).
- H_PIXELS, 480, expected RGB565 pixels per line.
- V_LINES, 272, expected lines per frame.

Ports:
- clk  input  1  camera pixel clock (cmos_pclk); all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- sdram_init_done  input  1  frame-buffer init complete; from the sdram clock domain; synchronized internally with 2 flops.
- cmos_vsync  input  1  frame sync; rising edge marks frame start.
- cmos_href  input  1  line valid; a byte is valid on each clk while high.
- cmos_data  input  8  pixel byte; high byte first.
- frame_valid  output  1  high once capture is running; feeds the bank-switch frame valid.
- frame_we  output  1  one-cycle write strobe per packed pixel.
- frame_data  output  16  packed RGB565 pixel: {first byte, second byte}.
- frame_cnt  output  8  completed captured frames; wraps modulo 256.
- size_err  output  1  sticky flag: bad line length, odd byte count, or wrong line count.

Behaviour:
- Reset values:
  - frame_valid=0, frame_we=0, frame_data=0, frame_cnt=0, size_err=0.
  - State S_INIT; all counters and byte toggle cleared.
  - Reset mid-frame aborts capture and returns to S_INIT.
- Input stage:
  - cmos_vsync, cmos_href and cmos_data are registered once (vs_d, hr_d, dat_d).
  - vs_edge = vs_d & ~vs_d2.
- State machine:
  - S_INIT: wait for synchronized init_done=1, then go to S_SKIP with skip_cnt=0.
  - S_SKIP: on each vs_edge, if skip_cnt==FRAME_SKIP go to S_RUN; else skip_cnt+1. With FRAME_SKIP=0, the first vs_edge enters S_RUN.
  - S_RUN: terminal state until rst. No writes occur outside S_RUN.
- frame_valid:
  - Set on the clk after the vs_edge that enters S_RUN, so it aligns to a frame start.
  - Stays high until rst. sdram_init_done dropping later is ignored.
- Byte packing (S_RUN only):
  - While hr_d=1, the toggle alternates each cycle.
  - toggle=0: latch dat_d as the high byte.
  - toggle=1: next cycle, frame_we=1 and frame_data={hi, dat_d}.
  - Latency: frame_we rises 2 clk after the second byte is present on cmos_data.
  - frame_data holds its value between strobes.
- Toggle clear: cleared whenever hr_d=0 and on vs_edge. vs_edge has priority over a simultaneous href byte; that byte is dropped.
- Odd bytes in a line: the dangling high byte is discarded and size_err is set.
- Size checks:
  - pix_cnt (12-bit, saturating at 4095) counts frame_we within a line.
  - On the href falling edge (hr_d=0, hr_d2=1): if pix_cnt!=H_PIXELS set size_err. Then line_cnt+1 (10-bit, saturating) and pix_cnt=0.
  - On vs_edge in S_RUN, except the edge that enters S_RUN: if line_cnt!=V_LINES set size_err; frame_cnt+1. line_cnt=0 on every vs_edge.
- size_err is cleared only by rst.
- Throughput: at most one frame_we per 2 clk. No backpressure; the downstream write FIFO must absorb a full line.

Test Plan:
- Init gating: hold sdram_init_done=0, send 3 frames of 480x272 -> frame_we never asserts, frame_valid=0, frame_cnt=0.
- Frame skip, FRAME_SKIP=2: init_done=1, then 4 vsync frames.
  - frame_valid rises 1 clk after the 3rd vs_edge.
  - Writes occur only in frames 3 and 4: 130560 strobes each.
  - frame_cnt=1 at the 4th vs_edge.
- Packing/latency: byte stream 0xF8,0x1F,0x07,0xE0 with href high.
  - frame_we pulses twice, 2 clk apart.
  - frame_data=0xF81F, then 0x07E0.
  - First strobe 2 clk after 0x1F is on the pins.
- Size errors:
  - Line of 479 pixels -> size_err=1 at the href falling edge.
  - Separate run with 271 lines -> size_err=1 at the next vs_edge.
  - Line with 961 bytes -> 480 writes, size_err=1.
- Simultaneous and reset events:
  - vsync rising while href high mid-byte-pair -> the pair is dropped, the toggle restarts at the next line.
  - rst pulse mid-line -> all outputs 0 the next clk; the skip count restarts after init_done.

Source files
------------

// File: rtl/cmos_capture_rgb565.sv
// OV5640 DVP capture: packs byte pairs into RGB565 words after skipping start-up frames,
// and flags frames whose line length, byte parity or line count do not match the expected geometry.
module cmos_capture_rgb565 #(
    parameter int unsigned FRAME_SKIP = 10,
    parameter int unsigned H_PIXELS   = 480,
    parameter int unsigned V_LINES    = 272
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        frame_valid,
    output logic        frame_we,
    output logic [15:0] frame_data,
    output logic [7:0]  frame_cnt,
    output logic        size_err
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_SKIP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [7:0]  SKIP_LIM = 8'(FRAME_SKIP);
    localparam logic [11:0] H_LIM    = 12'(H_PIXELS);
    localparam logic [9:0]  V_LIM    = 10'(V_LINES);

    state_t      state_r;
    state_t      state_s;
    logic        init_s1_r;
    logic        init_s2_r;
    logic        vs_d_r;
    logic        vs_d2_r;
    logic        hr_d_r;
    logic        hr_d2_r;
    logic [7:0]  dat_d_r;
    logic [7:0]  skip_cnt_r;
    logic        toggle_r;
    logic [7:0]  hi_byte_r;
    logic [11:0] pix_cnt_r;
    logic [9:0]  line_cnt_r;
    logic        frame_valid_r;
    logic        frame_we_r;
    logic [15:0] frame_data_r;
    logic [7:0]  frame_cnt_r;
    logic        size_err_r;
    logic        vs_edge_s;
    logic        run_s;

    assign vs_edge_s = vs_d_r & ~vs_d2_r;
    assign run_s     = (state_r == S_RUN);

    // Init-done synchronizer and one-stage registering of the DVP pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_s1_r <= 1'b0;
            init_s2_r <= 1'b0;
            vs_d_r    <= 1'b0;
            vs_d2_r   <= 1'b0;
            hr_d_r    <= 1'b0;
            hr_d2_r   <= 1'b0;
            dat_d_r   <= 8'd0;
        end else begin
            init_s1_r <= sdram_init_done;
            init_s2_r <= init_s1_r;
            vs_d_r    <= cmos_vsync;
            vs_d2_r   <= vs_d_r;
            hr_d_r    <= cmos_href;
            hr_d2_r   <= hr_d_r;
            dat_d_r   <= cmos_data;
        end
    end

    // Capture state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; S_RUN is only left through reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_INIT: begin
                if (init_s2_r) state_s = S_SKIP;
                else           state_s = S_INIT;
            end
            S_SKIP: begin
                if (vs_edge_s && (skip_cnt_r == SKIP_LIM)) state_s = S_RUN;
                else                                       state_s = S_SKIP;
            end
            S_RUN:   state_s = S_RUN;
            default: state_s = S_INIT;
        endcase
    end

    // Counts discarded frames while waiting for capture to start.
    always_ff @(posedge clk) begin
        if (rst || (state_r == S_INIT)) begin
            skip_cnt_r <= 8'd0;
        end else if ((state_r == S_SKIP) && vs_edge_s && (skip_cnt_r != SKIP_LIM)) begin
            skip_cnt_r <= skip_cnt_r + 8'd1;
        end else begin
            skip_cnt_r <= skip_cnt_r;
        end
    end

    // Byte packing, write strobe and frame geometry checks; vsync wins over a coincident byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_r      <= 1'b0;
            hi_byte_r     <= 8'd0;
            pix_cnt_r     <= 12'd0;
            line_cnt_r    <= 10'd0;
            frame_valid_r <= 1'b0;
            frame_we_r    <= 1'b0;
            frame_data_r  <= 16'd0;
            frame_cnt_r   <= 8'd0;
            size_err_r    <= 1'b0;
        end else begin
            frame_we_r    <= 1'b0;
            frame_valid_r <= (state_s == S_RUN);
            if (vs_edge_s) begin
                toggle_r   <= 1'b0;
                line_cnt_r <= 10'd0;
                if (run_s) begin
                    if (line_cnt_r != V_LIM) size_err_r <= 1'b1;
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end else if (!hr_d_r) begin
                toggle_r  <= 1'b0;
                pix_cnt_r <= 12'd0;
                if (hr_d2_r && run_s) begin
                    // A set toggle here means the line ended on a dangling high byte.
                    if ((pix_cnt_r != H_LIM) || toggle_r) size_err_r <= 1'b1;
                    if (line_cnt_r != 10'h3FF) line_cnt_r <= line_cnt_r + 10'd1;
                end
            end else if (run_s) begin
                toggle_r <= ~toggle_r;
                if (!toggle_r) begin
                    hi_byte_r <= dat_d_r;
                end else begin
                    frame_we_r   <= 1'b1;
                    frame_data_r <= {hi_byte_r, dat_d_r};
                    if (pix_cnt_r != 12'hFFF) pix_cnt_r <= pix_cnt_r + 12'd1;
                end
            end
        end
    end

    assign frame_valid = frame_valid_r;
    assign frame_we    = frame_we_r;
    assign frame_data  = frame_data_r;
    assign frame_cnt   = frame_cnt_r;
    assign size_err    = size_err_r;

endmodule

// File: tb/tb_cmos_capture_rgb565.sv
// Scoreboard bench for cmos_capture_rgb565 with a small frame geometry and a frame-level reference model.
module tb_cmos_capture_rgb565;

    localparam int SKIP = 2;
    localparam int H    = 8;
    localparam int V    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sdram_init_done = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = 8'd0;
    logic        frame_valid;
    logic        frame_we;
    logic [15:0] frame_data;
    logic [7:0]  frame_cnt;
    logic        size_err;

    cmos_capture_rgb565 #(.FRAME_SKIP(SKIP), .H_PIXELS(H), .V_LINES(V)) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .cmos_vsync      (cmos_vsync),
        .cmos_href       (cmos_href),
        .cmos_data       (cmos_data),
        .frame_valid     (frame_valid),
        .frame_we        (frame_we),
        .frame_data      (frame_data),
        .frame_cnt       (frame_cnt),
        .size_err        (size_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int errors   = 0;

    // Reference model: frame-level view of which pixels must be written.
    bit          init_on = 1'b0;
    int          vs_seen = 0;
    bit          capturing = 1'b0;
    int          lines_frame = 0;
    bit          exp_err = 1'b0;
    int          exp_fcnt = 0;
    logic [15:0] exp_q[$];
    int          we_cyc_q[$];
    logic [7:0]  line_b[$];
    int          b1_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected pixel.
    always @(negedge clk) begin
        if (frame_we === 1'b1) begin
            logic [15:0] e;
            n_checks++;
            we_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %h expected none", frame_data);
            end else begin
                e = exp_q.pop_front();
                if (frame_data !== e) begin
                    errors++;
                    $display("FAIL pixel_data: got %h expected %h", frame_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_vsync();
        if (init_on) begin
            if (capturing) begin
                if (lines_frame != V) exp_err = 1'b1;
                exp_fcnt++;
            end else if (vs_seen == SKIP) begin
                capturing = 1'b1;
            end else begin
                vs_seen++;
            end
            lines_frame = 0;
        end
    endtask

    task automatic pulse_vsync();
        model_vsync();
        cmos_vsync = 1'b1;
        idle(4);
        cmos_vsync = 1'b0;
        idle(4);
    endtask

    task automatic send_bytes();
        int n;
        n = line_b.size();
        if (capturing) begin
            for (int i = 0; i + 1 < n; i += 2) exp_q.push_back({line_b[i], line_b[i+1]});
            lines_frame++;
            if (n != 2 * H) exp_err = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            cmos_href = 1'b1;
            cmos_data = line_b[i];
            if (i == 1) b1_cyc = cyc;
            tick();
        end
        cmos_href = 1'b0;
        cmos_data = 8'($urandom);
        idle(3 + $urandom_range(0, 3));
    endtask

    task automatic send_line(input int n);
        line_b.delete();
        for (int i = 0; i < n; i++) line_b.push_back(8'($urandom));
        send_bytes();
    endtask

    task automatic send_frame();
        pulse_vsync();
        repeat (V) send_line(2 * H);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmos_href = 1'b0;
        cmos_vsync = 1'b0;
        idle(2);
        rst = 1'b0;
        vs_seen = 0;
        capturing = 1'b0;
        lines_frame = 0;
        exp_err = 1'b0;
        exp_fcnt = 0;
        exp_q.delete();
        idle(5);
    endtask

    task automatic enter_run();
        repeat (SKIP + 1) pulse_vsync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("rst_frame_valid", 32'(frame_valid), 32'(0));
        chk("rst_frame_we",    32'(frame_we),    32'(0));
        chk("rst_frame_data",  32'(frame_data),  32'(0));
        chk("rst_frame_cnt",   32'(frame_cnt),   32'(0));
        chk("rst_size_err",    32'(size_err),    32'(0));
        rst = 1'b0;
        idle(3);

        // Init gating: nothing may be written while the frame buffer is not ready.
        repeat (3) send_frame();
        chk("gate_frame_valid", 32'(frame_valid), 32'(0));
        chk("gate_frame_cnt",   32'(frame_cnt),   32'(0));
        chk("gate_writes",      32'(we_cyc_q.size()), 32'(0));

        sdram_init_done = 1'b1;
        init_on = 1'b1;
        idle(6);
        send_frame();
        send_frame();
        chk("skip_fv_low", 32'(frame_valid), 32'(0));
        pulse_vsync();
        chk("skip_fv_high", 32'(frame_valid), 32'(1));
        repeat (V) send_line(2 * H);
        pulse_vsync();
        chk("skip_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        chk("skip_frame_cnt_one", 32'(frame_cnt), 32'(1));
        repeat (V) send_line(2 * H);
        sdram_init_done = 1'b0;
        repeat (3) send_frame();
        pulse_vsync();
        chk("run_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        chk("run_size_err", 32'(size_err), 32'(exp_err));
        chk("run_fv_kept", 32'(frame_valid), 32'(1));
        sdram_init_done = 1'b1;

        // Packing and latency on a known byte stream.
        we_cyc_q.delete();
        line_b.delete();
        line_b.push_back(8'hF8); line_b.push_back(8'h1F);
        line_b.push_back(8'h07); line_b.push_back(8'hE0);
        send_bytes();
        chk("pack_count", 32'(we_cyc_q.size()), 32'(2));
        if (we_cyc_q.size() >= 2) begin
            chk("pack_latency", 32'(we_cyc_q[0]), 32'(b1_cyc + 2));
            chk("pack_spacing", 32'(we_cyc_q[1]), 32'(we_cyc_q[0] + 2));
        end
        chk("pack_hold_data", 32'(frame_data), 32'(16'h07E0));
        chk("pack_size_err", 32'(size_err), 32'(1));

        // Reset in the middle of a line.
        cmos_href = 1'b1;
        cmos_data = 8'hAA;
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_frame_valid", 32'(frame_valid), 32'(0));
        chk("mid_rst_frame_we",    32'(frame_we),    32'(0));
        chk("mid_rst_frame_data",  32'(frame_data),  32'(0));
        chk("mid_rst_frame_cnt",   32'(frame_cnt),   32'(0));
        chk("mid_rst_size_err",    32'(size_err),    32'(0));
        do_reset();
        send_frame();
        send_frame();
        chk("reskip_fv_low", 32'(frame_valid), 32'(0));
        pulse_vsync();
        chk("reskip_fv_high", 32'(frame_valid), 32'(1));
        repeat (V) send_line(2 * H);
        pulse_vsync();
        chk("reskip_frame_cnt", 32'(frame_cnt), 32'(1));

        // Short line.
        chk("short_err_before", 32'(size_err), 32'(0));
        send_line(2 * H - 2);
        chk("short_err_after", 32'(size_err), 32'(1));

        // Missing line in a frame.
        do_reset();
        enter_run();
        repeat (V - 1) send_line(2 * H);
        chk("lines_err_before", 32'(size_err), 32'(0));
        pulse_vsync();
        chk("lines_err_after", 32'(size_err), 32'(1));

        // Odd byte count with a full pixel count.
        do_reset();
        enter_run();
        we_cyc_q.delete();
        send_line(2 * H + 1);
        chk("odd_writes", 32'(we_cyc_q.size()), 32'(H));
        chk("odd_err", 32'(size_err), 32'(1));

        // Vsync arriving together with the low byte of a pair drops that pair.
        line_b.delete();
        line_b.push_back(8'h11); line_b.push_back(8'h22);
        line_b.push_back(8'h33); line_b.push_back(8'h44);
        exp_q.push_back(16'h1122);
        model_vsync();
        for (int i = 0; i < 4; i++) begin
            cmos_href = 1'b1;
            cmos_data = line_b[i];
            if (i == 3) cmos_vsync = 1'b1;
            tick();
        end
        cmos_href = 1'b0;
        idle(4);
        cmos_vsync = 1'b0;
        idle(4);
        chk("vs_mid_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
        send_line(2 * H);

        idle(10);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
